word_serializer: RTL and testbench

- Parallel-to-serial front end that feeds the single-bit serial sequence detector: accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per Clk.
- Has a one-word holding register, so back-to-back words stream with no idle cycle between them.
- Its out/out_valid drive the detector's serial input; word_start/word_end mark word boundaries for debug and for the bench.

---
 rtl/word_serializer_pkg.sv | 15 +
 rtl/word_serializer.sv | 90 +++++++++
 tb/tb_word_serializer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared constants and helpers for the word serializer and its serial-detector context.
package word_serializer_pkg;

    localparam logic       IDLE_BIT_DEFAULT = 1'b0;
    localparam logic [6:0] DETECT_PATTERN   = 7'b1101101;

    // Bits needed to index 0..v-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter with a one-word holding register so words stream
// back-to-back; drives the serial input of the sequence detector.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             stall,
    output logic             out,
    output logic             out_valid,
    output logic             word_start,
    output logic             word_end,
    output logic             busy
);

    localparam int unsigned     CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic             active_q;
    logic [WIDTH-1:0] sh_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;

    logic             accept;
    logic             consume;
    logic             last;
    logic             handoff_din;
    logic [WIDTH-1:0] sh_shifted;

    // Handshake and shift qualifiers come only from registers, din_valid and stall.
    assign accept      = din_valid & ~hold_full_q;
    assign consume     = active_q & ~stall;
    assign last        = active_q & (cnt_q == CNT_LAST);
    assign handoff_din = consume & last & ~hold_full_q & accept;
    assign sh_shifted  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    assign din_ready  = ~hold_full_q;
    assign out        = active_q ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
    assign out_valid  = consume;
    assign word_start = consume & (cnt_q == '0);
    assign word_end   = consume & last;
    assign busy       = active_q | hold_full_q;

    // Shifter, word handoff and holding register.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            active_q    <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (consume) begin
                if (!last) begin
                    sh_q  <= sh_shifted;
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (hold_full_q) begin
                    sh_q        <= hold_q;
                    cnt_q       <= '0;
                    hold_full_q <= 1'b0;
                end else if (accept) begin
                    sh_q  <= din;
                    cnt_q <= '0;
                end else begin
                    active_q <= 1'b0;
                    cnt_q    <= '0;
                end
            end else if (!active_q && accept) begin
                sh_q     <= din;
                cnt_q    <= '0;
                active_q <= 1'b1;
            end

            // A word arriving while the shifter is busy parks in hold, unless it feeds the handoff directly.
            if (active_q && accept && !handoff_din) begin
                hold_q      <= din;
                hold_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three configurations checked each cycle against a word-queue model,
// plus directed scenarios with hand-computed stream expectations.
module tb_word_serializer;
    import word_serializer_pkg::*;

    logic        Clk;
    logic        Clr;
    logic [31:0] din_s [3];
    logic        dv    [3];
    logic        st    [3];
    logic        rdy   [3];
    logic        o     [3];
    logic        ov    [3];
    logic        ws    [3];
    logic        we    [3];
    logic        bsy   [3];

    int n_assert;
    int n_fail;
    bit chk_en;

    // instance 0: W=7 MSB first; instance 1: W=8 LSB first; instance 2: W=8 MSB first
    word_serializer #(.WIDTH(7), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
        .Clk(Clk), .Clr(Clr), .din(din_s[0][6:0]), .din_valid(dv[0]), .din_ready(rdy[0]),
        .stall(st[0]), .out(o[0]), .out_valid(ov[0]), .word_start(ws[0]), .word_end(we[0]), .busy(bsy[0]));
    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
        .Clk(Clk), .Clr(Clr), .din(din_s[1][7:0]), .din_valid(dv[1]), .din_ready(rdy[1]),
        .stall(st[1]), .out(o[1]), .out_valid(ov[1]), .word_start(ws[1]), .word_end(we[1]), .busy(bsy[1]));
    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u2 (
        .Clk(Clk), .Clr(Clr), .din(din_s[2][7:0]), .din_valid(dv[2]), .din_ready(rdy[2]),
        .stall(st[2]), .out(o[2]), .out_valid(ov[2]), .word_start(ws[2]), .word_end(we[2]), .busy(bsy[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int wof(input int i);
        return (i == 0) ? 7 : 8;
    endfunction

    function automatic bit msbof(input int i);
        return (i != 1);
    endfunction

    task automatic chk(input string nm, input int i, input logic got, input logic exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t got=%b exp=%b", nm, i, $time, got, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    // Model: each instance is a FIFO of at most two words (in flight + held) and a bit position.
    logic [31:0] mw0  [3];
    logic [31:0] mw1  [3];
    int          mcnt [3];
    int          midx [3];

    always @(posedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            int   w;
            logic acc, cons, lastb;
            logic [31:0] mask, word;
            w     = wof(i);
            mask  = 32'((64'd1 << w) - 64'd1);
            word  = din_s[i] & mask;
            acc   = dv[i] && (mcnt[i] < 2);
            cons  = (mcnt[i] > 0) && !st[i];
            lastb = cons && (midx[i] == w - 1);
            if (Clr) begin
                mcnt[i] = 0;
                midx[i] = 0;
            end else begin
                if (cons) begin
                    if (lastb) begin
                        midx[i] = 0;
                        mw0[i]  = mw1[i];
                        mcnt[i] = mcnt[i] - 1;
                    end else begin
                        midx[i] = midx[i] + 1;
                    end
                end
                if (acc) begin
                    if (mcnt[i] == 0) mw0[i] = word;
                    else              mw1[i] = word;
                    mcnt[i] = mcnt[i] + 1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                int   w, bi;
                logic act, eb, eov;
                w   = wof(i);
                act = (mcnt[i] > 0);
                bi  = msbof(i) ? (w - 1 - midx[i]) : midx[i];
                eb  = act ? mw0[i][bi] : 1'b0;
                eov = act && !st[i];
                chk("out", i, o[i], eb);
                chk("out_valid", i, ov[i], eov);
                chk("word_start", i, ws[i], eov && (midx[i] == 0));
                chk("word_end", i, we[i], eov && (midx[i] == w - 1));
                chk("din_ready", i, rdy[i], mcnt[i] < 2);
                chk("busy", i, bsy[i], act);
            end
        end
    end

    // Stream capture for the directed scenarios.
    logic [63:0] cap [3];
    int cap_n [3], run [3], maxrun [3], ws_pos [3], we_pos [3];
    int ws_cyc [3], we_cyc [3], rdy0 [3], hold1 [3];
    int cyc;

    always @(negedge Clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (ov[i] === 1'b1) begin
                if (ws[i] === 1'b1) begin ws_pos[i] = cap_n[i]; ws_cyc[i] = cyc; end
                if (we[i] === 1'b1) begin we_pos[i] = cap_n[i]; we_cyc[i] = cyc; end
                cap[i]   = {cap[i][62:0], o[i]};
                cap_n[i] = cap_n[i] + 1;
                run[i]   = run[i] + 1;
                if (run[i] > maxrun[i]) maxrun[i] = run[i];
            end else begin
                run[i] = 0;
                if (bsy[i] === 1'b1 && o[i] === 1'b1) hold1[i] = hold1[i] + 1;
            end
            if (rdy[i] === 1'b0) rdy0[i] = rdy0[i] + 1;
        end
    end

    task automatic clr_cap();
        for (int i = 0; i < 3; i++) begin
            cap[i] = '0; cap_n[i] = 0; run[i] = 0; maxrun[i] = 0;
            ws_pos[i] = -1; we_pos[i] = -1; ws_cyc[i] = 0; we_cyc[i] = 0;
            rdy0[i] = 0; hold1[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [13:0] exp14;
        n_assert = 0; n_fail = 0; chk_en = 0; cyc = 0;
        clr_cap();
        for (int i = 0; i < 3; i++) begin
            din_s[i] = 32'hFFFF_FFFF; dv[i] = 1'b1; st[i] = 1'b0;
            mw0[i] = '0; mw1[i] = '0; mcnt[i] = 0; midx[i] = 0;
        end
        Clr = 1'b1;

        // Two reset cycles with din_valid asserted: nothing may be accepted.
        step();
        chk_en = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_out", i, o[i], 1'b0);
            chk("rst_out_valid", i, ov[i], 1'b0);
            chk("rst_din_ready", i, rdy[i], 1'b1);
            chk("rst_busy", i, bsy[i], 1'b0);
        end
        Clr = 1'b0;
        for (int i = 0; i < 3; i++) dv[i] = 1'b0;
        step();
        for (int i = 0; i < 3; i++) chk("post_rst_busy", i, bsy[i], 1'b0);

        // Single detector-pattern word, W=7 MSB first.
        clr_cap();
        din_s[0] = 32'(DETECT_PATTERN); dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        repeat (10) step();
        chk_vec("single_nbits", 64'(cap_n[0]), 64'd7);
        chk_vec("single_stream", 64'(cap[0][6:0]), 64'(7'b1101101));
        chk_vec("single_start_pos", 64'(ws_pos[0]), 64'd0);
        chk_vec("single_end_pos", 64'(we_pos[0]), 64'd6);
        chk_vec("single_contig", 64'(maxrun[0]), 64'd7);
        chk("single_busy_after", 0, bsy[0], 1'b0);

        // Back-to-back words stream without a gap.
        clr_cap();
        din_s[0] = 32'(DETECT_PATTERN); dv[0] = 1'b1;
        step();
        din_s[0] = 32'h13;
        step();
        dv[0] = 1'b0;
        repeat (20) step();
        exp14 = {7'b1101101, 7'b0010011};
        chk_vec("b2b_nbits", 64'(cap_n[0]), 64'd14);
        chk_vec("b2b_stream", 64'(cap[0][13:0]), 64'(exp14));
        chk_vec("b2b_contig", 64'(maxrun[0]), 64'd14);
        chk_vec("b2b_ready_low", 64'(rdy0[0]), 64'd6);

        // LSB-first, W=8.
        clr_cap();
        din_s[1] = 32'hA5; dv[1] = 1'b1;
        step();
        dv[1] = 1'b0;
        repeat (11) step();
        chk_vec("lsb_nbits", 64'(cap_n[1]), 64'd8);
        chk_vec("lsb_stream", 64'(cap[1][7:0]), 64'h00A5);
        chk_vec("lsb_end_pos", 64'(we_pos[1]), 64'd7);

        // Three-cycle stall while bit 3 of 8'hF0 is on out.
        clr_cap();
        din_s[2] = 32'hF0; dv[2] = 1'b1;
        step();
        dv[2] = 1'b0;
        repeat (3) step();
        st[2] = 1'b1;
        repeat (3) step();
        st[2] = 1'b0;
        repeat (10) step();
        chk_vec("stall_nbits", 64'(cap_n[2]), 64'd8);
        chk_vec("stall_stream", 64'(cap[2][7:0]), 64'h00F0);
        chk_vec("stall_span", 64'(we_cyc[2] - ws_cyc[2] + 1), 64'd11);
        chk_vec("stall_hold_cycles", 64'(hold1[2]), 64'd3);

        // Reset at bit 4 with a word held: everything discarded.
        din_s[2] = 32'h3C; dv[2] = 1'b1;
        step();
        din_s[2] = 32'hC3;
        step();
        dv[2] = 1'b0;
        repeat (3) step();
        chk("midrst_hold_full", 2, rdy[2], 1'b0);
        Clr = 1'b1;
        step();
        chk("midrst_out", 2, o[2], 1'b0);
        chk("midrst_out_valid", 2, ov[2], 1'b0);
        chk("midrst_din_ready", 2, rdy[2], 1'b1);
        chk("midrst_busy", 2, bsy[2], 1'b0);
        Clr = 1'b0;
        clr_cap();
        repeat (12) step();
        chk_vec("midrst_residual_bits", 64'(cap_n[2]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
